// File: rtl/fifo_rd_fwft_stage_pkg.sv
// Shared constants and helpers for the FIFO read-side FWFT stage.
// Provides the data width default, legal read latencies and clog2.
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int RD_LAT_MIN     = 1;
    localparam int RD_LAT_MAX     = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_rd_fwft_stage_if.sv
// Output stream of the FWFT stage: m_valid / m_ready / m_data.
// master drives valid+data, slave drives ready.
interface fifo_rd_fwft_stage_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (output m_valid, output m_data, input  m_ready);
    modport slave  (input  m_valid, input  m_data, output m_ready);

endinterface

// File: rtl/fifo_rd_fwft_stage_rd_lat_pipe.sv
// Read-return tag pipe: LAT-stage shift of issued-read tags.
// Ports: r_clk/rrst_n (sync, active-low), tag_i in, tag_o out, cnt_o in-flight count.
module rd_lat_pipe
    import fifo_pkg::*;
#(
    parameter int LAT = 1,
    parameter int CW  = clog2(LAT + 1)
) (
    input  logic          r_clk,
    input  logic          rrst_n,
    input  logic          tag_i,
    output logic          tag_o,
    output logic [CW-1:0] cnt_o
);

    logic [LAT-1:0] stg_q;
    logic [LAT-1:0] stg_d;

    always_comb begin
        stg_d    = '0;
        stg_d[0] = tag_i;
        for (int i = 1; i < LAT; i++) begin
            stg_d[i] = stg_q[i-1];
        end
    end

    always_ff @(posedge r_clk) begin
        if (!rrst_n) stg_q <= '0;
        else         stg_q <= stg_d;
    end

    assign tag_o = stg_q[LAT-1];

    // Tags still in the pipe are reads whose data has not landed yet.
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < LAT; i++) begin
            cnt_o = cnt_o + CW'(stg_q[i]);
        end
    end

endmodule

// File: rtl/fifo_rd_fwft_stage.sv
// FWFT read stage: issues FIFO reads on credit into a small output buffer.
// Ports: r_clk, rrst_n (sync, active-low), r_empty/r_en/r_data raw read side,
// m_if (m_valid/m_ready/m_data stream), occupancy, ovf_err (sticky).
module fifo_rd_fwft_stage
    import fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int  RD_LATENCY = 1,
    parameter int  OUT_DEPTH  = 4,
    localparam int OW         = clog2(OUT_DEPTH) + 1
) (
    input  logic                  r_clk,
    input  logic                  rrst_n,
    input  logic                  r_empty,
    output logic                  r_en,
    input  logic [DATA_WIDTH-1:0] r_data,
    fifo_rd_fwft_stage_if.master  m_if,
    output logic [OW-1:0]         occupancy,
    output logic                  ovf_err
);

    localparam int AW = clog2(OUT_DEPTH);
    localparam int CW = clog2(RD_LATENCY + 1);
    localparam int SW = OW + 1;

    logic [DATA_WIDTH-1:0] mem_q [OUT_DEPTH];
    logic [AW-1:0]         head_q, head_d;
    logic [AW-1:0]         tail_q, tail_d;
    logic [OW-1:0]         occ_q, occ_d;
    logic                  ovf_q, ovf_d;

    logic          rd_vld;
    logic [CW-1:0] infl;
    logic [SW-1:0] credit_used;
    logic          full;
    logic          m_valid;
    logic          pop;
    logic          wr;

    // Credit: buffered plus in-flight words must fit the buffer.
    // Only registered state feeds this, never m_ready.
    assign credit_used = SW'(occ_q) + SW'(infl);
    assign r_en = rrst_n & ~r_empty & (credit_used < SW'(OUT_DEPTH));

    rd_lat_pipe #(
        .LAT (RD_LATENCY),
        .CW  (CW)
    ) u_pipe (
        .r_clk  (r_clk),
        .rrst_n (rrst_n),
        .tag_i  (r_en),
        .tag_o  (rd_vld),
        .cnt_o  (infl)
    );

    assign full    = (occ_q == OW'(OUT_DEPTH));
    assign m_valid = (occ_q != '0);
    assign pop     = m_valid & m_if.m_ready;
    // A full buffer still accepts a return when the head leaves this cycle.
    assign wr      = rd_vld & (~full | pop);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        ovf_d  = ovf_q | (rd_vld & full & ~pop);
        if (pop) head_d = head_q + AW'(1);
        if (wr)  tail_d = tail_q + AW'(1);
        unique case (1'b1)
            wr & ~pop: occ_d = occ_q + OW'(1);
            pop & ~wr: occ_d = occ_q - OW'(1);
            default:   occ_d = occ_q;
        endcase
    end

    always_ff @(posedge r_clk) begin
        if (!rrst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge r_clk) begin
        if (wr) mem_q[tail_q] <= r_data;
    end

    // Gating keeps m_data at zero whenever nothing is buffered.
    assign m_if.m_valid = m_valid;
    assign m_if.m_data  = m_valid ? mem_q[head_q] : '0;
    assign occupancy    = occ_q;
    assign ovf_err      = ovf_q;

endmodule

// File: tb/tb_fifo_rd_fwft_stage.sv
// Bench for fifo_rd_fwft_stage: lane 0 at RD_LATENCY=1, lane 1 at RD_LATENCY=2.
// Source model plays the upstream FIFO; a scoreboard checks every popped word.
module tb_fifo_rd_fwft_stage;
    import fifo_pkg::*;

    logic r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    logic       rrst_n;
    logic       m_ready;
    logic       r_empty0, r_empty1;
    logic       r_en0, r_en1;
    logic [7:0] r_data0, r_data1;
    logic [2:0] occ0, occ1;
    logic       ovf0, ovf1;

    fifo_rd_fwft_stage_if #(.DATA_WIDTH(8)) if0 ();
    fifo_rd_fwft_stage_if #(.DATA_WIDTH(8)) if1 ();

    assign if0.m_ready = m_ready;
    assign if1.m_ready = m_ready;

    fifo_rd_fwft_stage #(
        .DATA_WIDTH (8),
        .RD_LATENCY (1),
        .OUT_DEPTH  (4)
    ) dut0 (
        .r_clk     (r_clk),
        .rrst_n    (rrst_n),
        .r_empty   (r_empty0),
        .r_en      (r_en0),
        .r_data    (r_data0),
        .m_if      (if0),
        .occupancy (occ0),
        .ovf_err   (ovf0)
    );

    fifo_rd_fwft_stage #(
        .DATA_WIDTH (8),
        .RD_LATENCY (2),
        .OUT_DEPTH  (4)
    ) dut1 (
        .r_clk     (r_clk),
        .rrst_n    (rrst_n),
        .r_empty   (r_empty1),
        .r_en      (r_en1),
        .r_data    (r_data1),
        .m_if      (if1),
        .occupancy (occ1),
        .ovf_err   (ovf1)
    );

    int vecs = 0;
    int errs = 0;

    logic [7:0] src0 [$];
    logic [7:0] src1 [$];
    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Upstream FIFO, latency 1: registered empty flag, data one edge later.
    initial begin : model0
        logic       iss;
        logic [7:0] w;
        r_empty0 = 1'b1;
        r_data0  = 8'hEE;
        forever begin
            @(negedge r_clk);
            iss = r_en0;
            w   = 8'hEE;
            if (iss && src0.size() != 0) w = src0.pop_front();
            @(posedge r_clk);
            #2;
            r_data0  = iss ? w : 8'hEE;
            r_empty0 = (src0.size() == 0);
        end
    end

    // Upstream FIFO, latency 2: one extra data register.
    initial begin : model1
        logic       iss;
        logic [7:0] w;
        logic [7:0] d1;
        r_empty1 = 1'b1;
        r_data1  = 8'hEE;
        d1       = 8'hEE;
        forever begin
            @(negedge r_clk);
            iss = r_en1;
            w   = 8'hEE;
            if (iss && src1.size() != 0) w = src1.pop_front();
            @(posedge r_clk);
            #2;
            r_data1  = d1;
            d1       = iss ? w : 8'hEE;
            r_empty1 = (src1.size() == 0);
        end
    end

    always @(negedge r_clk) begin
        if (rrst_n === 1'b1 && if0.m_valid === 1'b1 && m_ready) begin
            if (exp0.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL beat0: got %0h expected none", if0.m_data);
            end else begin
                chk("beat0", 32'(if0.m_data), 32'(exp0.pop_front()));
            end
        end
    end

    always @(negedge r_clk) begin
        if (rrst_n === 1'b1 && if1.m_valid === 1'b1 && m_ready) begin
            if (exp1.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL beat1: got %0h expected none", if1.m_data);
            end else begin
                chk("beat1", 32'(if1.m_data), 32'(exp1.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge r_clk);
            #3;
        end
    endtask

    task automatic load(input logic [7:0] v);
        src0.push_back(v);
        src1.push_back(v);
        exp0.push_back(v);
        exp1.push_back(v);
    endtask

    function automatic logic [27:0] all_out();
        return {r_en0, if0.m_valid, occ0, ovf0, if0.m_data,
                r_en1, if1.m_valid, occ1, ovf1, if1.m_data};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int c0;
        int c1;
        rrst_n  = 1'b0;
        m_ready = 1'b1;
        tick(3);
        chk("reset", 32'(all_out()), 0);
        rrst_n = 1'b1;
        for (int j = 0; j < 20; j++) begin
            tick(1);
            chk("idle", 32'(all_out()), 0);
        end

        load(8'hA5);
        tick(1);
        chk("single_t1", {r_en0, r_en1, if0.m_valid, if1.m_valid}, 4'b1100);
        tick(1);
        chk("single_t2", {r_en0, r_en1, if0.m_valid, if1.m_valid}, 4'b0000);
        tick(1);
        chk("single_t3", {r_en0, r_en1, if0.m_valid, if1.m_valid}, 4'b0010);
        chk("single_d0", 32'(if0.m_data), 32'hA5);
        tick(1);
        chk("single_t4", {r_en0, r_en1, if0.m_valid, if1.m_valid}, 4'b0001);
        chk("single_d1", 32'(if1.m_data), 32'hA5);
        tick(1);
        chk("single_t5", {r_en0, r_en1, if0.m_valid, if1.m_valid}, 4'b0000);
        tick(3);

        for (int v = 0; v < 16; v++) load(8'(v));
        for (int j = 1; j <= 20; j++) begin
            tick(1);
            chk("stream_ctl", {r_en0, r_en1, if0.m_valid, if1.m_valid},
                {(j <= 16), (j <= 16), (j >= 3 && j <= 18), (j >= 4 && j <= 19)});
            chk("stream_occ", {occ0, occ1},
                {3'(j >= 3 && j <= 18), 3'(j >= 4 && j <= 19)});
        end
        tick(2);

        m_ready = 1'b0;
        for (int v = 0; v < 8; v++) load(8'h10 + 8'(v));
        c0 = 0;
        c1 = 0;
        for (int j = 1; j <= 10; j++) begin
            tick(1);
            c0 += int'(r_en0);
            c1 += int'(r_en1);
            if (j >= 7)
                chk("bp_hold", {if0.m_valid, if1.m_valid, if0.m_data, if1.m_data},
                    {2'b11, 8'h10, 8'h10});
        end
        chk("bp_req0", c0, 4);
        chk("bp_req1", c1, 4);
        chk("bp_occ", {occ0, occ1}, {3'd4, 3'd4});
        m_ready = 1'b1;
        tick(20);
        chk("bp_drain", {occ0, occ1, ovf0, ovf1}, 0);
        chk("bp_q0", exp0.size(), 0);
        chk("bp_q1", exp1.size(), 0);

        m_ready = 1'b0;
        for (int v = 0; v < 8; v++) load(8'h20 + 8'(v));
        tick(5);
        chk("pre_rst", {occ0, occ1}, {3'd3, 3'd2});
        rrst_n = 1'b0;
        src0.delete();
        src1.delete();
        exp0.delete();
        exp1.delete();
        tick(1);
        rrst_n = 1'b1;
        chk("rst_mid", 32'(all_out()), 0);
        for (int j = 0; j < 8; j++) begin
            tick(1);
            chk("post_rst", 32'(all_out()), 0);
        end

        m_ready = 1'b1;
        load(8'h30);
        load(8'h31);
        tick(10);
        chk("recover", {occ0, occ1, ovf0, ovf1}, 0);
        chk("rec_q0", exp0.size(), 0);
        chk("rec_q1", exp1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
